// File: rtl/cmos_rgb565_capture_if.sv
// cmos_rgb565_capture_if
//   Bundles the camera DVP bus and the frame-buffer write bus. These are the
//   two buses seen by the capture stage.
//   master : the capture stage. It receives the DVP bus and drives the
//            write bus.
//   slave  : the surrounding system (sensor model / frame buffer). It drives
//            the DVP bus and receives the write bus.
//   Signals:
//     cmos_vsync, cmos_href, cmos_data[7:0] : DVP frame sync, line valid, byte
//     sys_we, sys_data_in[15:0]             : pixel write strobe and RGB565 word
//     frame_valid, frame_start              : capture-active level, frame pulse
interface cmos_rgb565_capture_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        frame_valid;
  logic        frame_start;

  modport master (
    input  cmos_vsync, cmos_href, cmos_data,
    output sys_we, sys_data_in, frame_valid, frame_start
  );

  modport slave (
    output cmos_vsync, cmos_href, cmos_data,
    input  sys_we, sys_data_in, frame_valid, frame_start
  );
endinterface

// File: rtl/cmos_rgb565_capture.sv
// cmos_rgb565_capture
//   This block runs in the camera pixel-clock domain. It packs DVP byte pairs
//   into RGB565 words for the SDRAM frame-buffer write side.
//   After SDRAM init, it discards SKIP_FRAMES frames while the sensor settles.
//   It clips every frame to H_ACTIVE x V_ACTIVE words.
//   Ports:
//     clk             : pixel clock (also the frame buffer write clock)
//     rst             : synchronous active-high reset
//     sdram_init_done : from the SDRAM domain, double-flop synchronised here
//     bus (master)    : DVP inputs; sys_we/sys_data_in/frame_valid/frame_start
//     line_cnt        : lines accepted in the current frame (saturates)
//     odd_byte_err    : sticky, a line ended on an odd byte count
module cmos_rgb565_capture #(
  parameter int H_ACTIVE       = 1024,
  parameter int V_ACTIVE       = 720,
  parameter int SKIP_FRAMES    = 10,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sdram_init_done,
  cmos_rgb565_capture_if.master        bus,
  output logic [10:0]                  line_cnt,
  output logic                         odd_byte_err
);
  localparam int PW = $clog2(H_ACTIVE + 1);

  typedef enum logic [1:0] {WAIT_INIT, WAIT_VS, SKIP, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      skip_cnt_q, skip_cnt_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [10:0]     line_cnt_q, line_cnt_d;
  logic            toggle_q, toggle_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic            sys_we_q, sys_we_d;
  logic [15:0]     sys_data_q, sys_data_d;
  logic            frame_start_q, frame_start_d;
  logic            odd_err_q, odd_err_d;

  logic            init_s1_q, init_s2_q;
  logic            vsync_r_q, vsync_rr_q, href_r_q, href_rr_q;
  logic [7:0]      data_r_q;

  // Normalise vsync polarity so that 1 always means "between frames".
  logic vs_act_r, vs_act_rr, vs_edge, href_fall;
  assign vs_act_r  = (VS_ACTIVE_HIGH != 0) ? vsync_r_q  : ~vsync_r_q;
  assign vs_act_rr = (VS_ACTIVE_HIGH != 0) ? vsync_rr_q : ~vsync_rr_q;
  assign vs_edge   = vs_act_r & ~vs_act_rr;
  assign href_fall = href_rr_q & ~href_r_q;

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    toggle_d      = toggle_q;
    hi_byte_d     = hi_byte_q;
    sys_we_d      = 1'b0;
    sys_data_d    = sys_data_q;
    frame_start_d = 1'b0;
    odd_err_d     = odd_err_q;

    if (!init_s2_q) begin
      // Losing SDRAM init from any state abandons the frame and any half pair.
      state_d    = WAIT_INIT;
      skip_cnt_d = '0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      toggle_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_INIT: state_d = WAIT_VS;
        WAIT_VS: begin
          if (vs_edge) begin
            state_d    = SKIP;
            skip_cnt_d = '0;
          end
        end
        SKIP: begin
          if (vs_edge) begin
            skip_cnt_d = skip_cnt_q + 8'd1;
            if (skip_cnt_d == 8'(SKIP_FRAMES)) begin
              state_d       = CAPTURE;
              frame_start_d = 1'b1;
              pix_cnt_d     = '0;
              line_cnt_d    = '0;
              toggle_d      = 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (href_fall) begin
            if (pix_cnt_q != '0 && line_cnt_q < 11'(V_ACTIVE))
              line_cnt_d = line_cnt_q + 11'd1;
            pix_cnt_d = '0;
            toggle_d  = 1'b0;
            if (toggle_q) odd_err_d = 1'b1;
          end else if (href_r_q && !vs_act_r) begin
            if (!toggle_q) begin
              hi_byte_d = data_r_q;
              toggle_d  = 1'b1;
            end else begin
              toggle_d = 1'b0;
              if (pix_cnt_q < PW'(H_ACTIVE) && line_cnt_q < 11'(V_ACTIVE)) begin
                sys_we_d   = 1'b1;
                sys_data_d = {hi_byte_q, data_r_q};
              end
              if (pix_cnt_q < PW'(H_ACTIVE))
                pix_cnt_d = PW'(pix_cnt_q + 1);
            end
          end
          // The frame clear comes after the line close, so it wins when both
          // happen in the same cycle.
          if (vs_edge) begin
            frame_start_d = 1'b1;
            pix_cnt_d     = '0;
            line_cnt_d    = '0;
            toggle_d      = 1'b0;
          end
        end
        default: state_d = WAIT_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_INIT;
      skip_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      toggle_q      <= 1'b0;
      hi_byte_q     <= '0;
      sys_we_q      <= 1'b0;
      sys_data_q    <= '0;
      frame_start_q <= 1'b0;
      odd_err_q     <= 1'b0;
      init_s1_q     <= 1'b0;
      init_s2_q     <= 1'b0;
      vsync_r_q     <= 1'b0;
      vsync_rr_q    <= 1'b0;
      href_r_q      <= 1'b0;
      href_rr_q     <= 1'b0;
      data_r_q      <= '0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      toggle_q      <= toggle_d;
      hi_byte_q     <= hi_byte_d;
      sys_we_q      <= sys_we_d;
      sys_data_q    <= sys_data_d;
      frame_start_q <= frame_start_d;
      odd_err_q     <= odd_err_d;
      init_s1_q     <= sdram_init_done;
      init_s2_q     <= init_s1_q;
      vsync_r_q     <= bus.cmos_vsync;
      vsync_rr_q    <= vsync_r_q;
      href_r_q      <= bus.cmos_href;
      href_rr_q     <= href_r_q;
      data_r_q      <= bus.cmos_data;
    end
  end

  assign bus.sys_we      = sys_we_q;
  assign bus.sys_data_in = sys_data_q;
  assign bus.frame_valid = (state_q == CAPTURE);
  assign bus.frame_start = frame_start_q;
  assign line_cnt        = line_cnt_q;
  assign odd_byte_err    = odd_err_q;
endmodule

// File: tb/tb_cmos_rgb565_capture.sv
module tb_cmos_rgb565_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_init_done;
  logic [10:0] line_cnt;
  logic        odd_byte_err;

  cmos_rgb565_capture_if bus ();

  cmos_rgb565_capture #(
    .H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(2), .VS_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
    .bus(bus), .line_cnt(line_cnt), .odd_byte_err(odd_byte_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Strobe monitor, sampled on the falling edge.
  int          total_we = 0;
  int          b2b_cnt  = 0;
  logic        prev_we  = 1'b0;
  logic [15:0] words [0:1023];

  always @(negedge clk) begin
    if (bus.sys_we) begin
      if (total_we < 1024) words[total_we] <= bus.sys_data_in;
      total_we <= total_we + 1;
      if (prev_we) b2b_cnt <= b2b_cnt + 1;
    end
    prev_we <= bus.sys_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.cmos_href = 1'b1;
    bus.cmos_data = b;
    tick();
  endtask

  task automatic end_line();
    bus.cmos_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
    end_line();
  endtask

  // vsync pulse. It returns frame_start one and two clocks after vsync is driven.
  task automatic vs_pulse(output logic fs1, output logic fs2);
    bus.cmos_href  = 1'b0;
    bus.cmos_vsync = 1'b1;
    tick(); fs1 = bus.frame_start;
    tick(); fs2 = bus.frame_start;
    tick();
    bus.cmos_vsync = 1'b0;
    repeat (2) tick();
  endtask

  logic fs1, fs2;
  int   base;

  initial begin
    rst = 1'b1;
    sdram_init_done = 1'b0;
    bus.cmos_vsync = 1'b0;
    bus.cmos_href  = 1'b0;
    bus.cmos_data  = 8'h00;
    repeat (3) tick();
    chk("rst_we",   {31'd0, bus.sys_we}, 0);
    chk("rst_data", {16'd0, bus.sys_data_in}, 0);
    chk("rst_fv",   {31'd0, bus.frame_valid}, 0);
    chk("rst_fs",   {31'd0, bus.frame_start}, 0);
    chk("rst_line", {21'd0, line_cnt}, 0);
    chk("rst_odd",  {31'd0, odd_byte_err}, 0);
    rst = 1'b0;
    sdram_init_done = 1'b1;
    repeat (4) tick();

    // Skip count: frames 1 and 2 are discarded, frame 3 is captured.
    base = total_we;
    vs_pulse(fs1, fs2);
    for (int l = 0; l < 4; l++) send_line(8, 8'h10);
    vs_pulse(fs1, fs2);
    for (int l = 0; l < 4; l++) send_line(8, 8'h10);
    chk("skip_no_we", total_we - base, 0);
    chk("skip_fv_low", {31'd0, bus.frame_valid}, 0);
    vs_pulse(fs1, fs2);
    chk("cap_fs_1clk", {31'd0, fs1}, 0);
    chk("cap_fs_2clk", {31'd0, fs2}, 1);
    chk("cap_fv", {31'd0, bus.frame_valid}, 1);
    base = total_we;
    for (int l = 0; l < 4; l++) send_line(8, 8'h10);
    chk("frame3_we", total_we - base, 8);
    chk("frame3_word0", {16'd0, words[base]}, 32'h1011);
    chk("frame3_line", {21'd0, line_cnt}, 2);

    // Packing and strobe latency.
    vs_pulse(fs1, fs2);
    chk("pack_fs", {31'd0, fs2}, 1);
    chk("pack_line_clr", {21'd0, line_cnt}, 0);
    send_byte(8'hA5);
    bus.cmos_data = 8'h3C; tick();
    chk("pack_we0_early", {31'd0, bus.sys_we}, 0);
    bus.cmos_data = 8'h0F; tick();
    chk("pack_we0", {31'd0, bus.sys_we}, 1);
    chk("pack_word0", {16'd0, bus.sys_data_in}, 32'hA53C);
    bus.cmos_data = 8'hF0; tick();
    chk("pack_gap", {31'd0, bus.sys_we}, 0);
    bus.cmos_href = 1'b0; tick();
    chk("pack_we1", {31'd0, bus.sys_we}, 1);
    chk("pack_word1", {16'd0, bus.sys_data_in}, 32'h0FF0);
    repeat (2) tick();
    chk("pack_line", {21'd0, line_cnt}, 1);
    chk("pack_odd", {31'd0, odd_byte_err}, 0);

    // Clipping: 3 lines x 12 bytes with a 4x2 window.
    vs_pulse(fs1, fs2);
    base = total_we;
    for (int l = 0; l < 3; l++) send_line(12, 8'h40 + 8'(16 * l));
    chk("clip_we", total_we - base, 8);
    chk("clip_line", {21'd0, line_cnt}, 2);
    chk("clip_w3", {16'd0, words[base + 3]}, 32'h4647);
    chk("clip_w4", {16'd0, words[base + 4]}, 32'h5051);

    // Odd line, then a good frame keeps the sticky flag.
    vs_pulse(fs1, fs2);
    base = total_we;
    send_line(7, 8'h20);
    chk("odd_we", total_we - base, 3);
    chk("odd_err", {31'd0, odd_byte_err}, 1);
    vs_pulse(fs1, fs2);
    base = total_we;
    for (int l = 0; l < 2; l++) send_line(8, 8'h30);
    chk("odd_good_we", total_we - base, 8);
    chk("odd_sticky", {31'd0, odd_byte_err}, 1);

    // Init loss mid-line, then a full re-skip.
    vs_pulse(fs1, fs2);
    send_line(8, 8'h60);
    for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
    sdram_init_done = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h74 + 8'(i));
    chk("loss_fv", {31'd0, bus.frame_valid}, 0);
    base = total_we;
    for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i));
    end_line();
    chk("loss_no_we", total_we - base, 0);
    sdram_init_done = 1'b1;
    repeat (4) tick();
    base = total_we;
    vs_pulse(fs1, fs2);
    send_line(8, 8'h90);
    vs_pulse(fs1, fs2);
    send_line(8, 8'h90);
    chk("reskip_no_we", total_we - base, 0);
    chk("reskip_fv", {31'd0, bus.frame_valid}, 0);
    vs_pulse(fs1, fs2);
    chk("reskip_fv_up", {31'd0, bus.frame_valid}, 1);
    base = total_we;
    send_line(8, 8'hA0);
    chk("reskip_we", total_we - base, 4);

    // Reset mid-line, just as a strobe is due.
    send_byte(8'hB0);
    send_byte(8'hB1);
    rst = 1'b1;
    tick();
    chk("mrst_we",   {31'd0, bus.sys_we}, 0);
    chk("mrst_data", {16'd0, bus.sys_data_in}, 0);
    chk("mrst_fv",   {31'd0, bus.frame_valid}, 0);
    chk("mrst_line", {21'd0, line_cnt}, 0);
    chk("mrst_odd",  {31'd0, odd_byte_err}, 0);
    rst = 1'b0;
    bus.cmos_href = 1'b0;
    repeat (4) tick();
    base = total_we;
    vs_pulse(fs1, fs2);
    send_line(8, 8'hC0);
    vs_pulse(fs1, fs2);
    send_line(8, 8'hC0);
    chk("mrst_skip_we", total_we - base, 0);
    chk("mrst_skip_fv", {31'd0, bus.frame_valid}, 0);

    chk("no_b2b", b2b_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmos_rgb565_capture.md
# cmos_rgb565_capture

Camera-side capture stage that feeds the SDRAM frame buffer write FIFO. It runs in the OV5640 pixel-clock domain and samples the 8-bit DVP bus (vsync, href, data). It packs byte pairs into RGB565 words and drives the frame buffer's `clk_write`/`sys_we`/`sys_data_in`/`frame_valid` inputs. It discards the first frames after SDRAM init while the sensor settles, and clips every frame to the configured active window so the buffer always receives at most `H_ACTIVE*V_ACTIVE` words per frame.

## Interface
Parameters:
- `H_ACTIVE`, 1024: pixels (16-bit words) accepted per line.
- `V_ACTIVE`, 720: lines accepted per frame.
- `SKIP_FRAMES`, 10: complete frames discarded before capture starts (1..255).
- `VS_ACTIVE_HIGH`, 1: 1 = vsync pulse high between frames; 0 = low.

Ports:
- `clk`  in  1  camera pixel clock (cmos_pclk); also drives frame buffer `clk_write`. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `sdram_init_done`  in  1  from SDRAM controller domain; double-flop synchronised internally.
- `cmos_vsync`  in  1  DVP frame sync.
- `cmos_href`  in  1  DVP line valid.
- `cmos_data`  in  8  DVP byte.
- `sys_we`  out  1  one-cycle write strobe per packed pixel.
- `sys_data_in`  out  16  RGB565 word, valid when `sys_we`=1.
- `frame_valid`  out  1  level, high once skipping completes; to bank switcher.
- `frame_start`  out  1  one-cycle pulse at the vsync active edge that begins a captured frame.
- `line_cnt`  out  11  lines accepted in the current frame (saturates at `V_ACTIVE`).
- `odd_byte_err`  out  1  sticky; set when href falls after an odd byte count.

## Operation
- Input stage: vsync, href and data are registered once (`*_r`). A vsync edge is detected on the `*_r` vs `*_rr` pair, with polarity normalised by `VS_ACTIVE_HIGH`.
- FSM states:
  - `WAIT_INIT`: the reset state. Moves to `WAIT_VS` when synchronised init_done=1.
  - `WAIT_VS`: waits for a vsync active edge, then moves to `SKIP` with skip_cnt=0.
  - `SKIP`: each vsync active edge increments skip_cnt. On the edge where skip_cnt reaches `SKIP_FRAMES`, the FSM moves to `CAPTURE`, sets `frame_valid`=1 and pulses `frame_start`.
  - `CAPTURE`: each subsequent vsync active edge pulses `frame_start` and clears the pixel/line counters.
- If synchronised init_done falls in any state, the FSM goes to `WAIT_INIT`, `frame_valid`=0 and counters clear. Any write pair in flight is dropped.
- Packing happens only in `CAPTURE` and only while href_r=1:
  - A byte toggle alternates. The first byte goes to [15:8], the second to [7:0].
  - On the second byte: `sys_we`=1 if pix_cnt<`H_ACTIVE` and line_cnt<`V_ACTIVE`; pix_cnt increments (saturating at `H_ACTIVE`).
- href_r falling edge (end of line):
  - line_cnt increments if pix_cnt>0 and line_cnt<`V_ACTIVE`.
  - pix_cnt and the toggle clear.
  - If the toggle was 1 (odd byte), the partial byte is discarded and `odd_byte_err` is set.
- Extra pixels beyond `H_ACTIVE` and extra lines beyond `V_ACTIVE` are counted but never written.
- A short line or short frame writes what arrived; no padding.
- href during vsync active is ignored.

## Timing
- Reset values: `sys_we`=0, `sys_data_in`=0, `frame_valid`=0, `frame_start`=0, `line_cnt`=0, `odd_byte_err`=0; FSM=`WAIT_INIT`; skip_cnt=0.
- Latency: the second byte sampled on edge k leads to `sys_we`/`sys_data_in` registered at edge k+1. That is 2 clocks from pins to strobe.
- `sys_we` max rate: one per 2 clocks. Never two consecutive cycles.
- `frame_start` asserts 2 clocks after the vsync active level first appears on the pins.
- Init_done synchroniser adds 2 clocks before any state effect.
- Vsync edge and href fall in the same cycle: the line is closed first, then the frame counters clear. The net result is counters=0.
- `rst` mid-frame: all outputs return to reset values on the next edge. Capture restarts from `WAIT_INIT` including the full skip.

## Test plan
- **Skip count:** init_done=1, `SKIP_FRAMES`=2, three frames of 4 lines × 8 bytes → no `sys_we` during frames 1–2. `frame_valid` rises at the 3rd vsync edge. Frame 3 yields exactly 16 strobes.
- **Packing:** byte sequence A5,3C,0F,F0 in `CAPTURE` → `sys_data_in`=16'hA53C then 16'h0FF0. Each strobe is 2 clocks after its second byte; the strobes are spaced 2 clocks apart.
- **Clipping:** `H_ACTIVE`=4, `V_ACTIVE`=2, sensor sends 3 lines × 12 bytes → 8 strobes total; `line_cnt`=2.
- **Odd line:** a line of 7 bytes → 3 strobes; `odd_byte_err`=1 and it stays 1 through later good frames until `rst`.
- **Init loss:** drop init_done mid-frame in `CAPTURE` → `frame_valid`=0 within 3 clocks and no further strobes. Re-assert it → a full `SKIP_FRAMES` skip occurs again before any writes.
- **Reset:** `rst` pulse mid-line → all outputs are 0 on the next cycle and capture stays idle until init_done is re-seen.
